alu_multicycle: RTL and testbench

//   Parametrised execute-stage ALU with valid/ready handshakes on both sides.

---
 rtl/alu_multicycle.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: logic/add/sub in one cycle, multiply/divide iterate one bit per cycle.
// Latency: single-cycle/invalid/divide-by-zero -> out_valid one cycle after accept; MUL*/DIV* -> WIDTH+1.
// Backpressure: o_in_ready only in IDLE; result and flags are held in DONE until i_out_ready retires them.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_in_valid / o_in_ready        operand handshake; i_op, i_num1, i_num2 captured on accept
//   o_out_valid / i_out_ready      result handshake
//   o_result_lo, o_result_hi       result / product {hi,lo} / quotient (lo) and remainder (hi)
//   o_comp_result                  unsigned num1 vs num2: 00 equal, 01 smaller, 10 larger
//   o_sig_comp_result              signed compare, same encoding
//   o_overflow, o_div_by_zero      ADD/SUB signed overflow, DIV min/-1; divide by zero
//   o_op_invalid                   unsupported op, result forced to 0
// Build option: define ALU_DIVIDER_EN to build the divider; otherwise DIVU/DIV report op_invalid.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [4:0]       i_op,
    input  logic [WIDTH-1:0] i_num1,
    input  logic [WIDTH-1:0] i_num2,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result_lo,
    output logic [WIDTH-1:0] o_result_hi,
    output logic [1:0]       o_comp_result,
    output logic [1:0]       o_sig_comp_result,
    output logic             o_overflow,
    output logic             o_div_by_zero,
    output logic             o_op_invalid
);
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_NOT  = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_MULU = 5'd6;
    localparam logic [4:0] OP_MUL  = 5'd7;
    localparam logic [4:0] OP_DIVU = 5'd8;
    localparam logic [4:0] OP_DIV  = 5'd9;
    localparam int         CW      = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Captured operands (compare outputs) and iteration datapath.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_mb;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_rem;  // running product high / partial remainder
    logic [WIDTH-1:0] r_quo;  // multiplier being consumed / dividend shifting into quotient
    logic             r_neg_q;
    logic [CW-1:0]    r_cnt;
`ifdef ALU_DIVIDER_EN
    logic             r_div;
    logic             r_neg_r;
    logic             r_div_ovf;
`endif

    // Output registers.
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [1:0]       r_cmp;
    logic [1:0]       r_scmp;
    logic             r_ovf;
    logic             r_dbz;
    logic             r_inv;

    logic             w_accept;
    logic             w_last;
    logic             w_is_multi;
    logic             w_signed_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic [WIDTH-1:0] w_sc_lo;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_ovf;
    logic             w_sc_dbz;
    logic             w_sc_inv;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [2*WIDTH-1:0] w_mul_res;

    function automatic logic [1:0] f_cmp(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic             sgn);
        logic lt;
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        return (a == b) ? 2'b00 : (lt ? 2'b01 : 2'b10);
    endfunction

    assign o_in_ready        = (r_state == S_IDLE);
    assign o_out_valid       = (r_state == S_DONE);
    assign o_result_lo       = r_lo;
    assign o_result_hi       = r_hi;
    assign o_comp_result     = r_cmp;
    assign o_sig_comp_result = r_scmp;
    assign o_overflow        = r_ovf;
    assign o_div_by_zero     = r_dbz;
    assign o_op_invalid      = r_inv;

    assign w_accept = i_in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Signed ops run the unsigned engine on magnitudes and fix signs at the end.
    assign w_signed_op = (i_op == OP_MUL) || (i_op == OP_DIV);
    assign w_a_neg     = w_signed_op && i_num1[WIDTH-1];
    assign w_b_neg     = w_signed_op && i_num2[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -i_num1 : i_num1;
    assign w_b_mag     = w_b_neg ? -i_num2 : i_num2;

    // Divide by zero is resolved at accept, so it never enters BUSY.
    always_comb begin
        w_is_multi = (i_op == OP_MULU) || (i_op == OP_MUL);
`ifdef ALU_DIVIDER_EN
        if (((i_op == OP_DIVU) || (i_op == OP_DIV)) && (i_num2 != '0)) begin
            w_is_multi = 1'b1;
        end
`endif
    end

    assign w_sum = i_num1 + i_num2;
    assign w_dif = i_num1 - i_num2;

    always_comb begin
        w_sc_lo  = '0;
        w_sc_hi  = '0;
        w_sc_ovf = 1'b0;
        w_sc_dbz = 1'b0;
        w_sc_inv = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sc_lo  = w_sum;
                w_sc_ovf = (i_num1[WIDTH-1] == i_num2[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != i_num1[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_lo  = w_dif;
                w_sc_ovf = (i_num1[WIDTH-1] != i_num2[WIDTH-1]) &&
                           (w_dif[WIDTH-1] != i_num1[WIDTH-1]);
            end
            OP_AND:  w_sc_lo = i_num1 & i_num2;
            OP_OR:   w_sc_lo = i_num1 | i_num2;
            OP_NOT:  w_sc_lo = ~i_num1;
            OP_XOR:  w_sc_lo = i_num1 ^ i_num2;
            OP_MULU, OP_MUL: ;
            OP_DIVU, OP_DIV: begin
`ifdef ALU_DIVIDER_EN
                if (i_num2 == '0) begin
                    w_sc_lo  = '1;
                    w_sc_hi  = i_num1;
                    w_sc_dbz = 1'b1;
                end
`else
                w_sc_inv = 1'b1;
`endif
            end
            default: w_sc_inv = 1'b1;
        endcase
    end

    // Shift-add multiply step: add multiplicand when the current multiplier bit is set,
    // then shift {carry, hi, lo} right; the multiplier drains out of lo as the product fills in.
    assign w_mul_sum  = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_mb} : {(WIDTH+1){1'b0}});
    assign w_mul_hi   = w_mul_sum[WIDTH:1];
    assign w_mul_lo   = {w_mul_sum[0], r_quo[WIDTH-1:1]};
    assign w_mul_prod = {w_mul_hi, w_mul_lo};
    assign w_mul_res  = r_neg_q ? -w_mul_prod : w_mul_prod;

`ifdef ALU_DIVIDER_EN
    // Restoring divide step: bring in the next dividend bit and keep the trial
    // subtraction only when it does not borrow.
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH:0]   w_div_trial;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    assign w_div_sh    = {r_rem, r_quo[WIDTH-1]};
    assign w_div_trial = w_div_sh - {1'b0, r_mb};
    assign w_div_rem   = w_div_trial[WIDTH] ? w_div_sh[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
    assign w_div_quo   = {r_quo[WIDTH-2:0], ~w_div_trial[WIDTH]};
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_is_multi ? S_BUSY : S_DONE;
            S_BUSY:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (i_out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_mb      <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_neg_q   <= 1'b0;
            r_cnt     <= '0;
`ifdef ALU_DIVIDER_EN
            r_div     <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div_ovf <= 1'b0;
`endif
            r_lo      <= '0;
            r_hi      <= '0;
            r_cmp     <= 2'b00;
            r_scmp    <= 2'b00;
            r_ovf     <= 1'b0;
            r_dbz     <= 1'b0;
            r_inv     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= i_num1;
                        r_b     <= i_num2;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
`ifdef ALU_DIVIDER_EN
                        r_div     <= (i_op == OP_DIVU) || (i_op == OP_DIV);
                        r_neg_r   <= w_a_neg;
                        r_div_ovf <= (i_op == OP_DIV) && (i_num2 == '1) &&
                                     (i_num1 == {1'b1, {(WIDTH-1){1'b0}}});
                        if ((i_op == OP_DIVU) || (i_op == OP_DIV)) begin
                            r_mb  <= w_b_mag;
                            r_quo <= w_a_mag;
                        end else
`endif
                        begin
                            r_mb  <= w_a_mag;
                            r_quo <= w_b_mag;
                        end
                        if (!w_is_multi) begin
                            r_lo   <= w_sc_lo;
                            r_hi   <= w_sc_hi;
                            r_cmp  <= f_cmp(i_num1, i_num2, 1'b0);
                            r_scmp <= f_cmp(i_num1, i_num2, 1'b1);
                            r_ovf  <= w_sc_ovf;
                            r_dbz  <= w_sc_dbz;
                            r_inv  <= w_sc_inv;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
`ifdef ALU_DIVIDER_EN
                    if (r_div) begin
                        r_rem <= w_div_rem;
                        r_quo <= w_div_quo;
                    end else
`endif
                    begin
                        r_rem <= w_mul_hi;
                        r_quo <= w_mul_lo;
                    end
                    if (w_last) begin
                        r_cmp  <= f_cmp(r_a, r_b, 1'b0);
                        r_scmp <= f_cmp(r_a, r_b, 1'b1);
                        r_dbz  <= 1'b0;
                        r_inv  <= 1'b0;
`ifdef ALU_DIVIDER_EN
                        if (r_div) begin
                            // min/-1 naturally yields quotient min-negative and remainder 0.
                            r_lo  <= r_neg_q ? -w_div_quo : w_div_quo;
                            r_hi  <= r_neg_r ? -w_div_rem : w_div_rem;
                            r_ovf <= r_div_ovf;
                        end else
`endif
                        begin
                            r_lo  <= w_mul_res[WIDTH-1:0];
                            r_hi  <= w_mul_res[2*WIDTH-1:WIDTH];
                            r_ovf <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
    localparam int LMC = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld, ir, ov, ordy;
    logic [4:0]  op;
    logic [31:0] a, b, lo, hi;
    logic [1:0]  cmp, scmp;
    logic        ovf, dbz, inv;
    logic [6:0]  act_fl;

    logic        vld8, ir8, ov8, ordy8;
    logic [4:0]  op8;
    logic [7:0]  a8, b8, lo8, hi8;
    logic [1:0]  cmp8, scmp8;
    logic        ovf8, dbz8, inv8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign act_fl = {cmp, scmp, ovf, dbz, inv};

    alu_multicycle #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(vld), .o_in_ready(ir), .i_op(op),
        .i_num1(a), .i_num2(b), .o_out_valid(ov), .i_out_ready(ordy),
        .o_result_lo(lo), .o_result_hi(hi), .o_comp_result(cmp), .o_sig_comp_result(scmp),
        .o_overflow(ovf), .o_div_by_zero(dbz), .o_op_invalid(inv));

    alu_multicycle #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(vld8), .o_in_ready(ir8), .i_op(op8),
        .i_num1(a8), .i_num2(b8), .o_out_valid(ov8), .i_out_ready(ordy8),
        .o_result_lo(lo8), .o_result_hi(hi8), .o_comp_result(cmp8), .o_sig_comp_result(scmp8),
        .o_overflow(ovf8), .o_div_by_zero(dbz8), .o_op_invalid(inv8));

    typedef struct {
        logic [31:0] lo, hi;
        logic [6:0]  fl;   // {comp, sig_comp, overflow, div_by_zero, op_invalid}
        int          lat;
    } exp_t;

    typedef struct {
        string       nm;
        logic [4:0]  op;
        logic [31:0] a, b;
        int          hold;
        exp_t        e;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int hold, input logic [31:0] elo, input logic [31:0] ehi,
                       input logic [6:0] efl, input int lat);
        vec_t v;
        v.nm = nm; v.op = o; v.a = x; v.b = y; v.hold = hold;
        v.e.lo = elo; v.e.hi = ehi; v.e.fl = efl; v.e.lat = lat;
        vt.push_back(v);
    endtask

    // Reference model: plain arithmetic on 64-bit values.
    function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint sx, sy, sr;
        logic [63:0] p;
        logic [1:0] c, sc;
        logic v, z, n;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        c  = (x == y) ? 2'd0 : ((x < y) ? 2'd1 : 2'd2);
        sc = (sx == sy) ? 2'd0 : ((sx < sy) ? 2'd1 : 2'd2);
        v = 1'b0; z = 1'b0; n = 1'b0;
        e.lo = '0; e.hi = '0; e.lat = 1;
        case (o)
            5'd0: begin sr = sx + sy; e.lo = 32'(sr); v = (sr != longint'($signed(e.lo))); end
            5'd1: begin sr = sx - sy; e.lo = 32'(sr); v = (sr != longint'($signed(e.lo))); end
            5'd2: e.lo = x & y;
            5'd3: e.lo = x | y;
            5'd4: e.lo = ~x;
            5'd5: e.lo = x ^ y;
            5'd6: begin p = {32'd0, x} * {32'd0, y}; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = LMC; end
            5'd7: begin p = 64'(sx * sy); e.hi = p[63:32]; e.lo = p[31:0]; e.lat = LMC; end
            5'd8, 5'd9: begin
`ifdef ALU_DIVIDER_EN
                if (y == 0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = x; z = 1'b1;
                end else if (o == 5'd8) begin
                    e.lo = x / y; e.hi = x % y; e.lat = LMC;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 0; v = 1'b1; e.lat = LMC;
                end else begin
                    e.lo = 32'(sx / sy); e.hi = 32'(sx % sy); e.lat = LMC;
                end
`else
                n = 1'b1;
`endif
            end
            default: n = 1'b1;
        endcase
        e.fl = {c, sc, v, z, n};
        return e;
    endfunction

    // Issue one op, check latency/results/flags, hold the result for 'hold' cycles
    // with junk offered upstream, then retire. Called and returns on a negedge.
    task automatic txn(input string nm, input logic [4:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int hold, input exp_t e);
        int lat, berr, herr;
        chk({nm, "_in_ready"}, 64'(ir), 64'd1);
        vld = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        lat = 1; berr = 0; herr = 0;
        while (!ov && lat < 200) begin
            if (ir) berr++;
            vld = 1'($urandom_range(0, 1)); op = 5'($urandom); a = $urandom; b = $urandom;
            @(negedge clk);
            lat++;
        end
        vld = 1'b0;
        chk({nm, "_lat"}, 64'(lat), 64'(e.lat));
        chk({nm, "_lo"}, 64'(lo), 64'(e.lo));
        chk({nm, "_hi"}, 64'(hi), 64'(e.hi));
        chk({nm, "_flags"}, 64'(act_fl), 64'(e.fl));
        chk({nm, "_busy_rdy"}, 64'(berr), 64'd0);
        for (int i = 0; i < hold; i++) begin
            vld = 1'b1; op = 5'd0; a = $urandom; b = $urandom;
            @(negedge clk);
            if ({ov, ir, lo, hi, act_fl} !== {1'b1, 1'b0, e.lo, e.hi, e.fl}) herr++;
        end
        chk({nm, "_hold"}, 64'(herr), 64'd0);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0; vld = 1'b0;
        chk({nm, "_retire"}, 64'({ov, ir}), 64'b01);
    endtask

    task automatic txn8(input string nm, input logic [4:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] ep);
        int lat;
        vld8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(negedge clk);
        vld8 = 1'b0; lat = 1;
        while (!ov8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'd9);
        chk({nm, "_prod"}, 64'({hi8, lo8}), 64'(ep));
        ordy8 = 1'b1;
        @(negedge clk);
        ordy8 = 1'b0;
        chk({nm, "_retire"}, 64'({ov8, ir8}), 64'b01);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int seen;
        logic [4:0] ro;
        logic [7:0] x8, y8;
        logic [15:0] p8;

        rst_n = 1'b0; vld = 1'b0; ordy = 1'b0; op = '0; a = '0; b = '0;
        vld8 = 1'b0; ordy8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;

        add("add_ovf",  5'd0, 32'h7FFF_FFFF, 32'd1, 0, 32'h8000_0000, 32'd0, 7'b10_10_100, 1);
        add("sub_ovf",  5'd1, 32'h8000_0000, 32'd1, 0, 32'h7FFF_FFFF, 32'd0, 7'b10_01_100, 1);
        add("and",      5'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 32'h0F00_0F00, 32'd0, 7'b10_01_000, 1);
        add("or",       5'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 32'hFFF0_FFF0, 32'd0, 7'b10_01_000, 1);
        add("not",      5'd4, 32'h1234_5678, 32'hFFFF_FFFF, 0, 32'hEDCB_A987, 32'd0, 7'b01_10_000, 1);
        add("xor_bp",   5'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 5, 32'h0FF0_0FF0, 32'd0, 7'b01_01_000, 1);
        add("mul_neg",  5'd7, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 7'b10_01_000, LMC);
        add("mulu_max", 5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0001, 32'hFFFF_FFFE, 7'b00_00_000, LMC);
        add("op31",     5'd31, 32'd5, 32'd5, 0, 32'd0, 32'd0, 7'b00_00_001, 1);
`ifdef ALU_DIVIDER_EN
        add("div_m7_2", 5'd9, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 7'b10_01_000, LMC);
        add("divu_7_0", 5'd8, 32'd7, 32'd0, 0, 32'hFFFF_FFFF, 32'd7, 7'b10_10_010, 1);
        add("div_min",  5'd9, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0, 7'b01_01_100, LMC);
        add("divu_10_2", 5'd8, 32'd10, 32'd2, 0, 32'd5, 32'd0, 7'b10_10_000, LMC);
`else
        add("div_m7_2", 5'd9, 32'hFFFF_FFF9, 32'd2, 0, 32'd0, 32'd0, 7'b10_01_001, 1);
        add("divu_7_0", 5'd8, 32'd7, 32'd0, 0, 32'd0, 32'd0, 7'b10_10_001, 1);
        add("div_min",  5'd9, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, 32'd0, 7'b01_01_001, 1);
        add("divu_10_2", 5'd8, 32'd10, 32'd2, 0, 32'd0, 32'd0, 7'b10_10_001, 1);
`endif

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_ready", 64'({ir, ir8}), 64'b11);
        chk("reset_valid", 64'({ov, ov8}), 64'b00);
        chk("reset_out", 64'({lo, hi}), 64'd0);
        chk("reset_flags", 64'(act_fl), 64'd0);

        foreach (vt[i]) txn(vt[i].nm, vt[i].op, vt[i].a, vt[i].b, vt[i].hold, vt[i].e);

        // Reset in the middle of a MULU: result abandoned, no late out_valid.
        vld = 1'b1; op = 5'd6; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(negedge clk);
        vld = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_busy", 64'({ir, ov}), 64'b00);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_ready", 64'(ir), 64'd1);
        chk("rst_mid_valid", 64'(ov), 64'd0);
        chk("rst_mid_out", 64'({lo, hi}), 64'd0);
        chk("rst_mid_flags", 64'(act_fl), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov) seen++;
        end
        chk("rst_no_pulse", 64'(seen), 64'd0);
        e.lo = 32'd5; e.hi = 32'd0; e.fl = 7'b01_01_000; e.lat = 1;
        txn("add_after_rst", 5'd0, 32'd2, 32'd3, 0, e);

        // Randomised transactions against the reference model.
        for (int i = 0; i < 150; i++) begin
            ro = 5'($urandom_range(0, 12));
            if (ro == 5'd12) ro = 5'd31;
            a = pick(); b = pick();
            e = model(ro, a, b);
            txn($sformatf("rnd%0d_op%0d", i, ro), ro, a, b, int'($urandom_range(0, 2)), e);
        end

        // Narrow instance: full-width product after WIDTH iterations.
        txn8("mulu8_ff", 5'd6, 8'hFF, 8'hFF, 16'hFE01);
        for (int i = 0; i < 20; i++) begin
            x8 = 8'($urandom); y8 = 8'($urandom);
            if ((i % 2) == 0) begin
                p8 = {8'd0, x8} * {8'd0, y8};
                txn8($sformatf("mulu8_%0d", i), 5'd6, x8, y8, p8);
            end else begin
                p8 = 16'(int'($signed(x8)) * int'($signed(y8)));
                txn8($sformatf("mul8_%0d", i), 5'd7, x8, y8, p8);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
